nem_ohmux_sel_ctrl: RTL and testbench
=====================================

// Module: nem_ohmux_sel_ctrl
// PURPOSE
//   Sequencer that drives the one-hot select lines S[N_IN-1:0] of a NEM-relay one-hot inverting mux.
//   Accepts encoded select requests over a valid/ready handshake.
//   Applies break-before-make: all selects are low for T_BREAK cycles before any new select rises.
//   Holds sel_valid low until the relay actuation settle time T_SETTLE has elapsed.
//   Counts relay actuations for endurance tracking. Sits between config/routing logic and the mux.
// PARAMETERS
//   N_IN      4    number of mux inputs = width of S; 2..16
//   SEL_W     2    width of req_sel; equals $clog2(N_IN)
//   T_BREAK   4    cycles with S==0 between releasing one select and asserting the next; >=1
//   T_SETTLE  8    cycles S is held before sel_valid rises; >=1
//   CNT_W     16   width of the actuation counter
// PORTS
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   1       request valid
//   req_ready  out  1       request ready
//   req_sel    in   SEL_W   requested input index
//   req_off    in   1       with req_valid: release all selects (req_sel ignored)
//   S          out  N_IN    one-hot select to the mux; registered
//   sel_valid  out  1       mux output is settled and valid for cur_sel
//   cur_sel    out  SEL_W   index of the currently asserted select (0 when off)
//   req_err    out  1       one-cycle pulse: rejected request (req_sel >= N_IN)
//   act_count  out  CNT_W   saturating count of select assertions since reset
// BEHAVIOUR
//   Reset (async, immediate): S=0, sel_valid=0, cur_sel=0, req_err=0, act_count=0, state OFF.
//   Reset asserted mid-sequence drops S to 0 at once; there is no break wait.
//   States: OFF, BREAK, SETTLE, ACTIVE. Down-counter cnt has width $clog2(max(T_BREAK,T_SETTLE)+1).
//   req_ready=1 only in OFF or ACTIVE, and is combinational from state.
//   A request is accepted on a rising edge with req_valid&&req_ready.
//   Invariants: $onehot0(S) in every cycle, and S never changes directly from one nonzero value
//     to another different nonzero value.
//   Accepted request, by priority:
//     1) req_off=1:
//        - from ACTIVE: S<=0, sel_valid<=0, cnt<=T_BREAK-1, go BREAK with target=OFF.
//        - from OFF: no-op.
//     2) req_sel>=N_IN: req_err<=1 for one cycle; state and outputs are unchanged.
//     3) ACTIVE and req_sel==cur_sel: no-op; sel_valid stays 1 and act_count is unchanged.
//     4) ACTIVE, different sel: S<=0, sel_valid<=0, latch target, cnt<=T_BREAK-1, go BREAK.
//     5) OFF: S<=onehot(req_sel), cur_sel<=req_sel, act_count++, cnt<=T_SETTLE-1, go SETTLE.
//        No break wait is needed because S is already 0.
//   BREAK:
//     - cnt!=0: cnt--.
//     - cnt==0 and target=OFF: go OFF, cur_sel<=0.
//     - cnt==0 otherwise: S<=onehot(target), cur_sel<=target, act_count++, cnt<=T_SETTLE-1, go SETTLE.
//   SETTLE:
//     - cnt!=0: cnt--.
//     - cnt==0: sel_valid<=1, go ACTIVE.
//   Latency with accept at edge k:
//     - switch from ACTIVE: S==0 for cycles k+1..k+T_BREAK; new S from k+T_BREAK+1;
//       sel_valid from k+T_BREAK+T_SETTLE+1.
//     - select from OFF: S at k+1; sel_valid at k+T_SETTLE+1.
//   act_count saturates at 2^CNT_W-1; there is no wrap.
//   req_valid with req_ready=0 (BREAK/SETTLE) is not accepted. The requester must hold the request.
// TESTING
//   Reset, then request sel=2 from OFF at edge k:
//     S=4'b0100 at k+1; sel_valid=1 at k+9; act_count=1.
//   From ACTIVE sel=2, request sel=0 at edge k:
//     S=0 for k+1..k+4; S=4'b0001 at k+5; sel_valid=1 at k+13; S never 4'b0101.
//   Request sel=0 while ACTIVE on 0:
//     accepted with no S glitch; sel_valid stays 1; act_count unchanged.
//   req_off from ACTIVE:
//     S=0 and sel_valid=0 next cycle; req_ready=0 for 4 cycles; then OFF with cur_sel=0.
//   Requests during SETTLE are held off (req_ready=0).
//   Reset mid-BREAK/SETTLE clears all outputs immediately.
//   N_IN=3, SEL_W=2, req_sel=3:
//     req_err pulses one cycle; S and state are unchanged.
//   Bench with CNT_W=4 and 20 alternating switches:
//     act_count saturates at 15.
//   Assertion $onehot0(S) is checked on every cycle of a random request stress run.

Source files
------------

// File: rtl/nem_ohmux_sel_ctrl.sv
// rtl/nem_ohmux_sel_ctrl.sv - break-before-make one-hot select sequencer for a NEM-relay mux
module nem_ohmux_sel_ctrl #(
   parameter int N_IN     = 4,
   parameter int SEL_W    = 2,
   parameter int T_BREAK  = 4,
   parameter int T_SETTLE = 8,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [SEL_W-1:0] req_sel,
   input  logic             req_off,
   output logic [N_IN-1:0]  S,
   output logic             sel_valid,
   output logic [SEL_W-1:0] cur_sel,
   output logic             req_err,
   output logic [CNT_W-1:0] act_count
);

   // One timer serves both the break and the settle phases, so it is sized for the longer one.
   localparam int T_MAX = (T_BREAK > T_SETTLE) ? T_BREAK : T_SETTLE;
   localparam int TC_W  = $clog2(T_MAX + 1);
   localparam logic [TC_W-1:0]  BRK_LD   = TC_W'(T_BREAK - 1);
   localparam logic [TC_W-1:0]  SET_LD   = TC_W'(T_SETTLE - 1);
   localparam logic [SEL_W:0]   N_IN_EXT = (SEL_W + 1)'(N_IN);

   typedef enum logic [1:0] {
      ST_OFF,
      ST_BREAK,
      ST_SETTLE,
      ST_ACTIVE
   } state_t;

   state_t            state_q;
   logic [TC_W-1:0]   cnt_q;
   logic [SEL_W-1:0]  tgt_q;
   logic              tgt_off_q;
   logic [N_IN-1:0]   s_q;
   logic              sel_valid_q;
   logic [SEL_W-1:0]  cur_sel_q;
   logic              req_err_q;
   logic [CNT_W-1:0]  act_count_q;
   logic [CNT_W-1:0]  act_count_d;
   logic              accept;
   logic              sel_bad;
   logic              same_sel;

   function automatic logic [N_IN-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [N_IN-1:0] v;
      for (int i = 0; i < N_IN; i++) begin
         v[i] = (idx == SEL_W'(i));
      end
      return v;
   endfunction

   // Handshake and request classification; ready is purely a function of the state.
   assign req_ready   = (state_q == ST_OFF) || (state_q == ST_ACTIVE);
   assign accept      = req_valid && req_ready;
   assign sel_bad     = ({1'b0, req_sel} >= N_IN_EXT);
   assign same_sel    = (req_sel == cur_sel_q);
   assign act_count_d = (act_count_q == '1) ? act_count_q : act_count_q + 1'b1;

   assign S         = s_q;
   assign sel_valid = sel_valid_q;
   assign cur_sel   = cur_sel_q;
   assign req_err   = req_err_q;
   assign act_count = act_count_q;

   // Sequencer: a select only rises from OFF or after a full break with S held at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_OFF;
         cnt_q       <= '0;
         tgt_q       <= '0;
         tgt_off_q   <= 1'b0;
         s_q         <= '0;
         sel_valid_q <= 1'b0;
         cur_sel_q   <= '0;
         req_err_q   <= 1'b0;
         act_count_q <= '0;
      end else begin
         req_err_q <= 1'b0;
         case (state_q)
            ST_OFF, ST_ACTIVE: begin
               if (accept) begin
                  if (req_off) begin
                     if (state_q == ST_ACTIVE) begin
                        s_q         <= '0;
                        sel_valid_q <= 1'b0;
                        tgt_off_q   <= 1'b1;
                        cnt_q       <= BRK_LD;
                        state_q     <= ST_BREAK;
                     end
                  end else if (sel_bad) begin
                     req_err_q <= 1'b1;
                  end else if (state_q == ST_ACTIVE) begin
                     if (!same_sel) begin
                        s_q         <= '0;
                        sel_valid_q <= 1'b0;
                        tgt_q       <= req_sel;
                        tgt_off_q   <= 1'b0;
                        cnt_q       <= BRK_LD;
                        state_q     <= ST_BREAK;
                     end
                  end else begin
                     // S is already zero in OFF, so the new select can rise at once.
                     s_q         <= onehot(req_sel);
                     cur_sel_q   <= req_sel;
                     act_count_q <= act_count_d;
                     cnt_q       <= SET_LD;
                     state_q     <= ST_SETTLE;
                  end
               end
            end
            ST_BREAK: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (tgt_off_q) begin
                  cur_sel_q <= '0;
                  state_q   <= ST_OFF;
               end else begin
                  s_q         <= onehot(tgt_q);
                  cur_sel_q   <= tgt_q;
                  act_count_q <= act_count_d;
                  cnt_q       <= SET_LD;
                  state_q     <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  sel_valid_q <= 1'b1;
                  state_q     <= ST_ACTIVE;
               end
            end
            default: state_q <= ST_OFF;
         endcase
      end
   end

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// tb/tb_nem_ohmux_sel_ctrl.sv - directed and table-driven bench for nem_ohmux_sel_ctrl
module tb_nem_ohmux_sel_ctrl;

   logic        clk = 1'b0;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;

   logic        a_rst_n = 1'b0;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [1:0]  a_sel = '0;
   logic        a_off = 1'b0;
   logic [3:0]  a_S;
   logic        a_sv;
   logic [1:0]  a_cur;
   logic        a_err;
   logic [15:0] a_act;

   logic        b_rst_n = 1'b0;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [1:0]  b_sel = '0;
   logic        b_off = 1'b0;
   logic [2:0]  b_S;
   logic        b_sv;
   logic [1:0]  b_cur;
   logic        b_err;
   logic [3:0]  b_act;

   always #5 clk = ~clk;

   nem_ohmux_sel_ctrl #(.N_IN(4), .SEL_W(2), .T_BREAK(4), .T_SETTLE(8), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .req_valid(a_valid), .req_ready(a_ready),
      .req_sel(a_sel), .req_off(a_off), .S(a_S), .sel_valid(a_sv),
      .cur_sel(a_cur), .req_err(a_err), .act_count(a_act)
   );

   nem_ohmux_sel_ctrl #(.N_IN(3), .SEL_W(2), .T_BREAK(2), .T_SETTLE(3), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .req_valid(b_valid), .req_ready(b_ready),
      .req_sel(b_sel), .req_off(b_off), .S(b_S), .sel_valid(b_sv),
      .cur_sel(b_cur), .req_err(b_err), .act_count(b_act)
   );

   typedef struct {
      logic        off;
      logic [1:0]  sel;
      logic [3:0]  exp_s;
      logic        exp_sv;
      logic [1:0]  exp_cur;
      logic [15:0] exp_act;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Waits for ready, presents one request for exactly one accepting edge, returns #1 after it.
   task automatic issue(input int which, input logic off, input logic [1:0] sel);
      int n;
      n = 0;
      @(negedge clk);
      while (((which == 0) ? a_ready : b_ready) !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (((which == 0) ? a_ready : b_ready) !== 1'b1) begin
         errors++;
         $display("FAIL issue_timeout dut %0d ready 0 expected 1", which);
      end else begin
         if (which == 0) begin a_valid = 1'b1; a_off = off; a_sel = sel; end
         else            begin b_valid = 1'b1; b_off = off; b_sel = sel; end
         @(posedge clk);
         #1;
         a_valid = 1'b0;
         b_valid = 1'b0;
      end
   endtask

   task automatic reset_a();
      @(negedge clk);
      a_rst_n = 1'b0;
      repeat (2) @(negedge clk);
      a_rst_n = 1'b1;
   endtask

   // Invariants on every cycle: at most one select high, never a direct select-to-select change.
   logic [3:0] a_prev = '0;
   logic [2:0] b_prev = '0;
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (!$onehot0(a_S) || (a_prev != 0 && a_S != 0 && a_S != a_prev)) begin
            errors++;
            $display("FAIL inv_a S %b prev %b", a_S, a_prev);
         end
         checks++;
         if (!$onehot0(b_S) || (b_prev != 0 && b_S != 0 && b_S != b_prev)) begin
            errors++;
            $display("FAIL inv_b S %b prev %b", b_S, b_prev);
         end
      end
      a_prev = a_S;
      b_prev = b_S;
   end

   initial begin
      tbl[0] = '{1'b0, 2'd2, 4'b0100, 1'b1, 2'd2, 16'd1};
      tbl[1] = '{1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 16'd2};
      tbl[2] = '{1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 16'd2};
      tbl[3] = '{1'b0, 2'd3, 4'b1000, 1'b1, 2'd3, 16'd3};
      tbl[4] = '{1'b1, 2'd1, 4'b0000, 1'b0, 2'd0, 16'd3};
      tbl[5] = '{1'b1, 2'd2, 4'b0000, 1'b0, 2'd0, 16'd3};
      tbl[6] = '{1'b0, 2'd1, 4'b0010, 1'b1, 2'd1, 16'd4};

      // Reset state, observed while reset is held.
      repeat (2) @(negedge clk);
      chk("rst_S", a_S, 0);
      chk("rst_sv", a_sv, 0);
      chk("rst_cur", a_cur, 0);
      chk("rst_err", a_err, 0);
      chk("rst_act", a_act, 0);
      chk("rst_ready", a_ready, 1);
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      mon_en  = 1'b1;

      // Table: one request each, then the settled outputs.
      for (int i = 0; i < 7; i++) begin
         issue(0, tbl[i].off, tbl[i].sel);
         repeat (16) @(negedge clk);
         chk($sformatf("tbl%0d_S", i), a_S, tbl[i].exp_s);
         chk($sformatf("tbl%0d_sv", i), a_sv, tbl[i].exp_sv);
         chk($sformatf("tbl%0d_cur", i), a_cur, tbl[i].exp_cur);
         chk($sformatf("tbl%0d_act", i), a_act, tbl[i].exp_act);
         chk($sformatf("tbl%0d_ready", i), a_ready, 1);
      end

      // Select from OFF: S next cycle, sel_valid after T_SETTLE.
      reset_a();
      issue(0, 1'b0, 2'd2);
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk);
         if (j == 1) chk("off_sel_S_k1", a_S, 4'b0100);
         if (j == 8) chk("off_sel_sv_k8", a_sv, 0);
         if (j == 9) begin
            chk("off_sel_sv_k9", a_sv, 1);
            chk("off_sel_act", a_act, 1);
         end
      end

      // Switch 2 -> 0 with a held request for 1 that must wait out BREAK and SETTLE.
      issue(0, 1'b0, 2'd0);
      a_valid = 1'b1; a_off = 1'b0; a_sel = 2'd1;
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk);
         if (j <= 4) chk($sformatf("sw_S0_k%0d", j), a_S, 0);
         if (j >= 5 && j <= 13) chk($sformatf("sw_S1_k%0d", j), a_S, 4'b0001);
         if (j <= 12) chk($sformatf("sw_ready_k%0d", j), a_ready, 0);
         if (j == 12) chk("sw_sv_k12", a_sv, 0);
         if (j == 13) begin
            chk("sw_sv_k13", a_sv, 1);
            chk("sw_ready_k13", a_ready, 1);
         end
         if (j == 14) chk("held_req_break", a_S, 0);
      end
      a_valid = 1'b0;
      repeat (15) @(negedge clk);
      chk("held_req_S", a_S, 4'b0010);
      chk("held_req_cur", a_cur, 1);
      chk("held_req_act", a_act, 3);

      // Same select while active: no glitch, no count.
      issue(0, 1'b0, 2'd1);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         chk($sformatf("same_S_k%0d", j), a_S, 4'b0010);
         chk($sformatf("same_sv_k%0d", j), a_sv, 1);
      end
      chk("same_act", a_act, 3);

      // Release from ACTIVE: off next cycle, busy through the break, then OFF.
      issue(0, 1'b1, 2'd0);
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         if (j == 1) begin
            chk("off_S", a_S, 0);
            chk("off_sv", a_sv, 0);
         end
         if (j <= 4) chk($sformatf("off_ready_k%0d", j), a_ready, 0);
         if (j == 5) begin
            chk("off_ready_k5", a_ready, 1);
            chk("off_cur", a_cur, 0);
         end
      end

      // Asynchronous reset during SETTLE.
      reset_a();
      issue(0, 1'b0, 2'd3);
      repeat (3) @(negedge clk);
      chk("settle_S_pre", a_S, 4'b1000);
      a_rst_n = 1'b0;
      #1;
      chk("rst_settle_S", a_S, 0);
      chk("rst_settle_cur", a_cur, 0);
      chk("rst_settle_act", a_act, 0);
      @(negedge clk);
      a_rst_n = 1'b1;

      // Asynchronous reset during BREAK.
      issue(0, 1'b0, 2'd3);
      repeat (12) @(negedge clk);
      issue(0, 1'b0, 2'd0);
      repeat (2) @(negedge clk);
      chk("break_ready_pre", a_ready, 0);
      a_rst_n = 1'b0;
      #1;
      chk("rst_break_ready", a_ready, 1);
      chk("rst_break_S", a_S, 0);
      chk("rst_break_cur", a_cur, 0);
      chk("rst_break_act", a_act, 0);
      @(negedge clk);
      a_rst_n = 1'b1;

      // Random stress; the invariant monitor checks every cycle.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         a_valid = 1'($urandom);
         a_off   = ($urandom_range(0, 7) == 0);
         a_sel   = 2'($urandom);
      end
      a_valid = 1'b0;

      // N_IN=3 instance: reject of req_sel=3 leaves everything unchanged.
      chk("b_rst_act", b_act, 0);
      issue(1, 1'b0, 2'd1);
      repeat (10) @(negedge clk);
      chk("b_sel1_S", b_S, 3'b010);
      chk("b_err_idle", b_err, 0);
      issue(1, 1'b0, 2'd3);
      @(negedge clk);
      chk("b_err_k1", b_err, 1);
      chk("b_err_S_k1", b_S, 3'b010);
      @(negedge clk);
      chk("b_err_k2", b_err, 0);
      chk("b_err_S_k2", b_S, 3'b010);
      chk("b_err_sv", b_sv, 1);
      chk("b_err_ready", b_ready, 1);
      chk("b_err_act", b_act, 1);

      // 20 alternating switches on a 4-bit counter: 1 + 20 saturates at 15.
      for (int i = 0; i < 20; i++) begin
         issue(1, 1'b0, (i % 2 == 0) ? 2'd0 : 2'd2);
         if (i == 12) begin
            repeat (8) @(negedge clk);
            chk("b_act_14", b_act, 14);
         end
      end
      repeat (10) @(negedge clk);
      chk("b_act_sat", b_act, 15);
      chk("b_sat_S", b_S, 3'b100);
      chk("b_sat_cur", b_cur, 2);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
